dcache_controller: RTL
======================

Name: dcache_controller

Overview:
- Direct-mapped, write-back, write-allocate L1 data cache controller in the MEM stage of the 5-stage RISC-V core.
- Sits between the MEM-stage load/store port and the 256-bit off-chip data memory.
- Produces the memory stall that freezes the pipeline and holds the MEM/WB register while a miss is serviced.
- Contains the tag store (valid, dirty, tag) and the data array internally.

Parameters:
- LINES, 32, number of cache lines (index width = log2(LINES) = 5)
- LINE_BITS, 256, line size in bits (32 bytes, 8 words)
- MEM_AW, 32, memory byte-address width

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-low reset
- cpu_req_i  in  1  MEM stage performs a load or store this cycle
- cpu_wr_i  in  1  1 = store, 0 = load
- cpu_addr_i  in  32  byte address (word aligned)
- cpu_data_i  in  32  store data
- cpu_data_o  out  32  load data
- cpu_stall_o  out  1  mem_stall to pipeline registers
- mem_enable_o  out  1  one-cycle memory request pulse
- mem_write_o  out  1  1 = line write-back, 0 = line fill
- mem_addr_o  out  32  line-aligned memory address
- mem_data_o  out  256  write-back line
- mem_data_i  in  256  fill line
- mem_ack_i  in  1  one-cycle completion from memory

Behaviour:
- Address split: word = addr[4:2], index = addr[9:5], tag = addr[31:10] (22 bits); addr[1:0] ignored.
- Hit: cpu_req_i & valid[index] & (tag_store[index] == tag).
- FSM states: IDLE, MISS, WRITEBACK, READMISS, READMISSOK. Reset state is IDLE.
- IDLE:
  - Read hit: cpu_data_o = selected word, combinational in the same cycle; cpu_stall_o = 0.
  - Write hit: at the clock edge, write cpu_data_i into the selected word and set dirty; cpu_stall_o = 0.
  - Miss: cpu_stall_o = 1 combinationally; next state MISS.
- MISS:
  - Victim valid & dirty: go to WRITEBACK, pulse mem_enable_o, mem_write_o = 1, mem_addr_o = {victim tag, index, 5'b0}, mem_data_o = victim line.
  - Otherwise: go to READMISS, pulse mem_enable_o, mem_write_o = 0, mem_addr_o = {tag, index, 5'b0}.
- WRITEBACK: on mem_ack_i, go to READMISS and issue the fill request (new enable pulse, mem_write_o = 0, fill address).
- READMISS: on mem_ack_i, load mem_data_i into the line, set tag, valid = 1, dirty = 0; go to READMISSOK.
- READMISSOK: go to IDLE unconditionally. The held request is then re-evaluated as a hit; a store merges into the filled line at that edge.
- Stall: cpu_stall_o = (IDLE & cpu_req_i & miss) | (state != IDLE).
- Miss latency: 4 cycles plus memory latency for a clean miss; add one memory round-trip for a dirty miss.
- Memory handshake:
  - mem_enable_o is exactly one cycle per request.
  - mem_addr_o, mem_write_o and mem_data_o are registered and held stable from the pulse until mem_ack_i.
  - Memory latency is arbitrary, 1 cycle or more.
  - mem_ack_i in IDLE or MISS is ignored.
- The upstream pipeline holds cpu_req_i, cpu_wr_i, cpu_addr_i and cpu_data_i stable while cpu_stall_o = 1.
- cpu_data_o = 0 when there is no hit in IDLE.
- cpu_req_i = 0: no state change, stall 0.
- Reset values (asynchronous, any state including mid-miss): state IDLE, all valid = 0, all dirty = 0, mem_enable_o = 0, mem_write_o = 0, mem_addr_o = 0, mem_data_o = 0, cpu_stall_o = 0. The data array is not reset.
- A mem_ack_i arriving after a reset is ignored.

Optional Feature:
- Macro: DCACHE_STATS_EN.
- Defined:
  - Adds ports hit_cnt_o[31:0] and miss_cnt_o[31:0], both reset to 0.
  - hit_cnt_o increments once per IDLE-cycle hit.
  - miss_cnt_o increments once per IDLE-to-MISS transition.
  - The hit that follows a fill counts as a hit.
  - Both counters saturate at 32'hFFFFFFFF.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Cold load 0x0000_0040, memory returns line with word0 = 0xDEADBEEF after 3 cycles -> one pulse, mem_write_o = 0, mem_addr_o = 0x40; stall drops in the IDLE cycle after READMISSOK; cpu_data_o = 0xDEADBEEF.
- Store 0x12345678 to 0x44 (line resident) -> stall 0; a subsequent load of 0x44 returns 0x12345678 with no memory pulse.
- Load 0x0000_0444 (same index 2, dirty victim) -> write-back pulse first (addr 0x40, mem_data_o word1 = 0x12345678); then fill pulse at addr 0x440 after the ack.
- Store miss to 0x84 -> fill, then merge. Line at 0x80 dirty with word1 = store data, other words equal memory data.
- Assert rst_i = 0 while in READMISS, then release and send a late mem_ack_i -> state IDLE, all outputs 0, ack ignored; the next load misses.
- With DCACHE_STATS_EN, run the above sequence -> counters match the expected hit/miss totals exactly; forcing hit_cnt to 0xFFFFFFFF and then hitting leaves it at 0xFFFFFFFF.

Source files
------------

// File: rtl/dcache_controller.sv
// dcache_controller: direct-mapped, write-back, write-allocate L1 data cache
// for the MEM stage. It holds the tag store (valid/dirty/tag) and the data
// array, stalls the pipeline while a miss is serviced, and talks to a
// 256-bit line-wide memory with a one-cycle enable / one-cycle ack handshake.
// Optional feature macro: DCACHE_STATS_EN (adds hit_cnt_o / miss_cnt_o).
module dcache_controller #(
    parameter int LINES     = 32,
    parameter int LINE_BITS = 256,
    parameter int MEM_AW    = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 cpu_req_i,
    input  logic                 cpu_wr_i,
    input  logic [MEM_AW-1:0]    cpu_addr_i,
    input  logic [31:0]          cpu_data_i,
    output logic [31:0]          cpu_data_o,
    output logic                 cpu_stall_o,
    output logic                 mem_enable_o,
    output logic                 mem_write_o,
    output logic [MEM_AW-1:0]    mem_addr_o,
    output logic [LINE_BITS-1:0] mem_data_o,
    input  logic [LINE_BITS-1:0] mem_data_i,
    input  logic                 mem_ack_i
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0]          hit_cnt_o,
    output logic [31:0]          miss_cnt_o
`endif
);

    localparam int IDX_W  = $clog2(LINES);
    localparam int OFF_W  = $clog2(LINE_BITS / 8);
    localparam int WORD_W = OFF_W - 2;
    localparam int TAG_W  = MEM_AW - IDX_W - OFF_W;

    typedef enum logic [2:0] {
        IDLE,
        MISS,
        WRITEBACK,
        READMISS,
        READMISSOK
    } state_e;

    state_e state_q, state_d;

    logic [LINES-1:0]     valid_q;
    logic [LINES-1:0]     dirty_q;
    logic [TAG_W-1:0]     tagStore_q [LINES];
    logic [LINE_BITS-1:0] dataArray_q [LINES];

    logic                 mem_enable_q, mem_enable_d;
    logic                 mem_write_q, mem_write_d;
    logic [MEM_AW-1:0]    mem_addr_q, mem_addr_d;
    logic [LINE_BITS-1:0] mem_data_q, mem_data_d;

    logic [WORD_W-1:0]    wordSel;
    logic [IDX_W-1:0]     lineIdx;
    logic [TAG_W-1:0]     reqTag;
    logic                 hit;
    logic                 idleHit;
    logic                 writeHit;
    logic                 fillEn;
    logic                 unused_byteOffset;

    // Byte offset bits are don't-care because accesses are word aligned.
    assign unused_byteOffset = ^cpu_addr_i[1:0];

    assign wordSel  = cpu_addr_i[OFF_W-1:2];
    assign lineIdx  = cpu_addr_i[OFF_W +: IDX_W];
    assign reqTag   = cpu_addr_i[MEM_AW-1 -: TAG_W];

    assign hit      = cpu_req_i && valid_q[lineIdx] && (tagStore_q[lineIdx] == reqTag);
    assign idleHit  = (state_q == IDLE) && hit;
    assign writeHit = idleHit && cpu_wr_i;
    assign fillEn   = (state_q == READMISS) && mem_ack_i;

    assign mem_enable_o = mem_enable_q;
    assign mem_write_o  = mem_write_q;
    assign mem_addr_o   = mem_addr_q;
    assign mem_data_o   = mem_data_q;

    // Next-state, memory request and CPU-facing outputs; request fields hold unless a new pulse is issued.
    always_comb begin
        state_d      = state_q;
        mem_enable_d = 1'b0;
        mem_write_d  = mem_write_q;
        mem_addr_d   = mem_addr_q;
        mem_data_d   = mem_data_q;
        cpu_stall_o  = (state_q != IDLE) || (cpu_req_i && !hit);
        cpu_data_o   = '0;

        if (idleHit) begin
            cpu_data_o = dataArray_q[lineIdx][{wordSel, 5'b00000} +: 32];
        end

        case (state_q)
            IDLE: begin
                if (cpu_req_i && !hit) begin
                    state_d = MISS;
                end
            end
            MISS: begin
                mem_enable_d = 1'b1;
                if (valid_q[lineIdx] && dirty_q[lineIdx]) begin
                    state_d     = WRITEBACK;
                    mem_write_d = 1'b1;
                    mem_addr_d  = {tagStore_q[lineIdx], lineIdx, {OFF_W{1'b0}}};
                    mem_data_d  = dataArray_q[lineIdx];
                end else begin
                    state_d     = READMISS;
                    mem_write_d = 1'b0;
                    mem_addr_d  = {reqTag, lineIdx, {OFF_W{1'b0}}};
                end
            end
            WRITEBACK: begin
                if (mem_ack_i) begin
                    state_d      = READMISS;
                    mem_enable_d = 1'b1;
                    mem_write_d  = 1'b0;
                    mem_addr_d   = {reqTag, lineIdx, {OFF_W{1'b0}}};
                end
            end
            READMISS: begin
                if (mem_ack_i) begin
                    state_d = READMISSOK;
                end
            end
            READMISSOK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Controller state, line status bits and the registered memory request, all cleared by reset.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q      <= IDLE;
            valid_q      <= '0;
            dirty_q      <= '0;
            mem_enable_q <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_data_q   <= '0;
        end else begin
            state_q      <= state_d;
            mem_enable_q <= mem_enable_d;
            mem_write_q  <= mem_write_d;
            mem_addr_q   <= mem_addr_d;
            mem_data_q   <= mem_data_d;
            if (fillEn) begin
                valid_q[lineIdx] <= 1'b1;
                dirty_q[lineIdx] <= 1'b0;
            end else if (writeHit) begin
                dirty_q[lineIdx] <= 1'b1;
            end
        end
    end

    // Tag and data storage is left unreset; a line is only trusted once its valid bit is set.
    always_ff @(posedge clk_i) begin
        if (fillEn) begin
            tagStore_q[lineIdx]  <= reqTag;
            dataArray_q[lineIdx] <= mem_data_i;
        end else if (writeHit) begin
            dataArray_q[lineIdx][{wordSel, 5'b00000} +: 32] <= cpu_data_i;
        end
    end

`ifdef DCACHE_STATS_EN
    logic [31:0] hitCnt_q;
    logic [31:0] missCnt_q;

    assign hit_cnt_o  = hitCnt_q;
    assign miss_cnt_o = missCnt_q;

    // Saturating hit/miss statistics; the hit that completes a refill counts as an ordinary hit.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            hitCnt_q  <= '0;
            missCnt_q <= '0;
        end else begin
            if (idleHit && (hitCnt_q != 32'hFFFF_FFFF)) begin
                hitCnt_q <= hitCnt_q + 32'd1;
            end
            if ((state_q == IDLE) && (state_d == MISS) && (missCnt_q != 32'hFFFF_FFFF)) begin
                missCnt_q <= missCnt_q + 32'd1;
            end
        end
    end
`endif

endmodule
